sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, the successor to the fixed-size sync FIFO under verification. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, and an occupancy count. It also adds registered write-acknowledge, overflow and underflow pulses, and a selectable standard or first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in one clock domain and is driven by the existing FIFO_IF-style testbench.

Parameters:
- FIFO_WIDTH, 16: data bit width (≥1).
- FIFO_DEPTH, 8: number of entries (≥2; need not be a power of two).
- AF_LEVEL, FIFO_DEPTH-1: almostfull asserts when count ≥ AF_LEVEL (1..FIFO_DEPTH).
- AE_LEVEL, 1: almostempty asserts when count ≤ AE_LEVEL (0..FIFO_DEPTH-1).
- READ_MODE, FIFO_STD: fifo_mode_e; FIFO_STD uses a registered read, FIFO_FWFT shows the head word.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- wr_en, in, 1: write request.
- data_in, in, FIFO_WIDTH: write data.
- rd_en, in, 1: read/pop request.
- data_out, out, FIFO_WIDTH: read data.
- wr_ack, out, 1: registered pulse, previous-cycle write accepted.
- overflow, out, 1: registered pulse, previous-cycle write rejected because full.
- underflow, out, 1: registered pulse, previous-cycle read rejected because empty.
- full, out, 1: count == FIFO_DEPTH (combinational from count).
- empty, out, 1: count == 0.
- almostfull, out, 1: count ≥ AF_LEVEL.
- almostempty, out, 1: count ≤ AE_LEVEL.
- count, out, $clog2(FIFO_DEPTH+1): occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count, data_out, wr_ack, overflow, underflow are all 0.
  - Resulting flags: empty=1, almostempty=1, full=0, almostfull=0 (given AF_LEVEL ≥ 1).
  - Memory contents are not reset.
  - Reset asserted mid-burst discards all entries immediately. The first write after deassertion lands at index 0.
- Write accept: wr_en && !full.
  - mem[wr_ptr] ← data_in; wr_ptr increments and wraps from FIFO_DEPTH-1 to 0.
  - wr_ack=1 in the next cycle, otherwise 0.
- Write reject: wr_en && full, except the simultaneous case below. Nothing is stored; overflow=1 in the next cycle.
- Read accept: rd_en && !empty. rd_ptr increments with wrap.
  - STD mode: data_out ← mem[rd_ptr] at the same edge, so valid one cycle after rd_en. data_out holds its value when no read is accepted.
  - FWFT mode: data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty. rd_en pops the displayed word.
- Read reject: rd_en && empty, except the simultaneous case below. underflow=1 in the next cycle; data_out is unchanged in STD mode.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: only the write is accepted, count +1, no underflow. FWFT shows the word from the next cycle.
  - Full: only the read is accepted, count −1, no overflow, no wr_ack.
- count: +1 on write-only accept, −1 on read-only accept, otherwise unchanged. It never exceeds FIFO_DEPTH and never goes below 0.
- Latency:
  - Write-to-not-empty: 1 cycle.
  - Write-to-read-data: STD 2 cycles (write edge, then read edge); FWFT 1 cycle.
- Elaboration checks: AF_LEVEL and AE_LEVEL outside their legal ranges cause an elaboration-time $error.

Decomposition:
- shared_pkg:
  - typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e.
  - Default constants FIFO_WIDTH_DEF=16 and FIFO_DEPTH_DEF=8.
  - Existing test_finished / finished_driving handshake items stay there.
- Sub-module fifo_mem:
  - FIFO_WIDTH × FIFO_DEPTH register array.
  - One synchronous write port and one asynchronous read address.
  - Pointers, count, flags and read-mode muxing stay in sync_fifo_param.

Test Plan:
1. Reset check: wr_en=1, data_in=3, rst_n=0 → empty=1, almostempty=1, count=0, full=0, wr_ack=0, data_out=0. Write 0xA5 after release → stored at index 0, count=1.
2. Fill to full (DEPTH=8): write 0..7 → wr_ack on each, almostfull at count=7, full at count=8. A 9th write of 0xFF → overflow=1 for one cycle, count stays 8. Read all 8 → 0..7 in order.
3. Drain past empty: read 8 times, then read once more → underflow=1 for one cycle; data_out holds 7 in STD mode, count=0.
4. Simultaneous accesses:
   - Empty, wr_en=rd_en=1 with data 0x11 → count=1, no underflow.
   - Half-full (4 entries), both set → count stays 4.
   - Full, both set → count=7, no overflow, no wr_ack.
5. Wrap-around with FIFO_DEPTH=5: 20 interleaved writes/reads with incrementing data → every value read in order, no flag glitches at the pointer wrap from 4 to 0.
6. FWFT mode: write 0x2A into empty → data_out=0x2A the next cycle without rd_en. rd_en → data_out changes to the next word or to 0 when empty. Mid-burst rst_n pulse at count=3 → count=0, empty=1 immediately.

Source files
------------

// File: rtl/shared_pkg.sv
// Types, defaults and bench handshake items shared by the parametrised sync FIFO
// and the FIFO_IF-style environment that drives it.
package shared_pkg;

   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

   localparam int FIFO_WIDTH_DEF = 16;
   localparam int FIFO_DEPTH_DEF = 8;

   // Driver/monitor handshake used by the surrounding verification environment.
   logic test_finished;
   logic finished_driving;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read address. Contents are deliberately not reset.
module fifo_mem #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [FIFO_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [FIFO_WIDTH-1:0] rd_data
);

   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// registered status pulses and a standard or first-word-fall-through read port.
module sync_fifo_param
   import shared_pkg::*;
#(
   parameter int         FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int         AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int         AE_LEVEL   = 1,
   parameter fifo_mode_e READ_MODE  = FIFO_STD
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wr_en,
   input  logic [FIFO_WIDTH-1:0]           data_in,
   input  logic                            rd_en,
   output logic [FIFO_WIDTH-1:0]           data_out,
   output logic                            wr_ack,
   output logic                            overflow,
   output logic                            underflow,
   output logic                            full,
   output logic                            empty,
   output logic                            almostfull,
   output logic                            almostempty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

   localparam int            PW       = $clog2(FIFO_DEPTH);
   localparam int            CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

   if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_af_check
      $error("sync_fifo_param: AF_LEVEL must lie in 1..FIFO_DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_ae_check
      $error("sync_fifo_param: AE_LEVEL must lie in 0..FIFO_DEPTH-1");
   end

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [FIFO_WIDTH-1:0] data_out_q, data_out_d, head_data;
   logic                  wr_ack_q, wr_ack_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_accept, rd_accept;

   assign full        = (count_q == DEPTH_C);
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q >= AF_C);
   assign almostempty = (count_q <= AE_C);
   assign count       = count_q;

   // A full FIFO still pops on a simultaneous read, but the write is refused.
   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;

   fifo_mem #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AW         (PW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_addr (rd_ptr_q),
      .rd_data (head_data)
   );

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      wr_ack_d    = wr_accept;
      overflow_d  = wr_en && full && !rd_en;
      underflow_d = rd_en && empty && !wr_en;

      if (wr_accept) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         if (READ_MODE == FIFO_STD) begin
            data_out_d = head_data;
         end
      end

      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign wr_ack    = wr_ack_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign data_out  = (READ_MODE == FIFO_FWFT) ? (empty ? '0 : head_data) : data_out_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: three instances (STD depth 8, STD depth 5,
// FWFT depth 8) share one stimulus stream; queue models predict read data.
module tb_sync_fifo_param;
   import shared_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         wr_en, rd_en;
   logic [W-1:0] data_in;

   logic [W-1:0] a_dout, b_dout, f_dout;
   logic         a_ack, a_ovf, a_unf, a_full, a_empty, a_af, a_ae;
   logic         b_ack, b_ovf, b_unf, b_full, b_empty, b_af, b_ae;
   logic         f_ack, f_ovf, f_unf, f_full, f_empty, f_af, f_ae;
   logic [3:0]   a_cnt, f_cnt;
   logic [2:0]   b_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [W-1:0] q8[$];
   logic [W-1:0] q5[$];
   logic [W-1:0] e8_dout, e5_dout;

   always #5 clk = ~clk;

   sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .READ_MODE(FIFO_STD)) u_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(a_dout), .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_unf),
      .full(a_full), .empty(a_empty), .almostfull(a_af), .almostempty(a_ae), .count(a_cnt));

   sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(5), .READ_MODE(FIFO_STD)) u_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(b_dout), .wr_ack(b_ack), .overflow(b_ovf), .underflow(b_unf),
      .full(b_full), .empty(b_empty), .almostfull(b_af), .almostempty(b_ae), .count(b_cnt));

   sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .READ_MODE(FIFO_FWFT)) u_f (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(f_dout), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf),
      .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae), .count(f_cnt));

   task automatic model_clear();
      q8.delete();
      q5.delete();
      e8_dout = '0;
      e5_dout = '0;
   endtask

   // One clock of stimulus; models decide acceptance from their occupancy before the edge.
   task automatic drive(input logic w, input logic r, input logic [W-1:0] d);
      logic w8, r8, w5, r5;
      wr_en = w; rd_en = r; data_in = d;
      w8 = w && (q8.size() < 8);
      r8 = r && (q8.size() > 0);
      w5 = w && (q5.size() < 5);
      r5 = r && (q5.size() > 0);
      if (r8) e8_dout = q8.pop_front();
      if (w8) q8.push_back(d);
      if (r5) e5_dout = q5.pop_front();
      if (w5) q5.push_back(d);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b0; data_in = 16'h3;
      @(posedge clk); #1;
      n_cmp++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", a_empty); end
      n_cmp++; if (a_ae !== 1'b1) begin n_fail++; $display("FAIL reset_almostempty: got %b want 1", a_ae); end
      n_cmp++; if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_cnt); end
      n_cmp++; if (a_full !== 1'b0 || a_af !== 1'b0) begin n_fail++; $display("FAIL reset_full_af: got %b%b want 00", a_full, a_af); end
      n_cmp++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack: got %b want 0", a_ack); end
      n_cmp++; if (a_dout !== 16'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0000", a_dout); end
      rst_n = 1'b1; wr_en = 1'b0;
      model_clear();
      drive(1'b1, 1'b0, 16'hA5);
      n_cmp++; if (a_cnt !== 4'd1) begin n_fail++; $display("FAIL first_write_count: got %0d want 1", a_cnt); end
      n_cmp++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL first_write_ack: got %b want 1", a_ack); end
      n_cmp++; if (u_a.u_mem.mem_q[0] !== 16'hA5) begin n_fail++; $display("FAIL first_write_index0: got %h want 00a5", u_a.u_mem.mem_q[0]); end
      n_cmp++; if (a_empty !== 1'b0) begin n_fail++; $display("FAIL first_write_not_empty: got %b want 0", a_empty); end
   endtask

   task automatic test_fill_full();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, W'(i));
         n_cmp++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL fill_ack[%0d]: got %b want 1", i, a_ack); end
         n_cmp++; if (a_cnt !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, a_cnt, i + 1); end
         n_cmp++; if (a_af !== (i + 1 >= 7)) begin n_fail++; $display("FAIL fill_almostfull[%0d]: got %b want %b", i, a_af, (i + 1 >= 7)); end
         n_cmp++; if (a_full !== (i + 1 == 8)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, a_full, (i + 1 == 8)); end
      end
      drive(1'b1, 1'b0, 16'hFF);
      n_cmp++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_pulse: got %b want 1", a_ovf); end
      n_cmp++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL overflow_no_ack: got %b want 0", a_ack); end
      n_cmp++; if (a_cnt !== 4'd8) begin n_fail++; $display("FAIL overflow_count: got %0d want 8", a_cnt); end
      drive(1'b0, 1'b0, '0);
      n_cmp++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_one_cycle: got %b want 0", a_ovf); end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, '0);
         n_cmp++; if (a_dout !== e8_dout || a_dout !== W'(i)) begin n_fail++; $display("FAIL read_order[%0d]: got %h want %h", i, a_dout, W'(i)); end
         n_cmp++; if (a_cnt !== 4'(7 - i)) begin n_fail++; $display("FAIL read_count[%0d]: got %0d want %0d", i, a_cnt, 7 - i); end
      end
   endtask

   task automatic test_drain_underflow();
      drive(1'b0, 1'b1, '0);
      n_cmp++; if (a_unf !== 1'b1) begin n_fail++; $display("FAIL underflow_pulse: got %b want 1", a_unf); end
      n_cmp++; if (a_dout !== 16'h7) begin n_fail++; $display("FAIL underflow_hold: got %h want 0007", a_dout); end
      n_cmp++; if (a_cnt !== 4'd0 || a_empty !== 1'b1) begin n_fail++; $display("FAIL underflow_count: got %0d/%b want 0/1", a_cnt, a_empty); end
      drive(1'b0, 1'b0, '0);
      n_cmp++; if (a_unf !== 1'b0) begin n_fail++; $display("FAIL underflow_one_cycle: got %b want 0", a_unf); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      drive(1'b1, 1'b1, 16'h11);
      n_cmp++; if (a_cnt !== 4'd1) begin n_fail++; $display("FAIL simul_empty_count: got %0d want 1", a_cnt); end
      n_cmp++; if (a_unf !== 1'b0 || a_ack !== 1'b1) begin n_fail++; $display("FAIL simul_empty_unf_ack: got %b%b want 01", a_unf, a_ack); end
      n_cmp++; if (f_dout !== 16'h11) begin n_fail++; $display("FAIL simul_empty_fwft: got %h want 0011", f_dout); end
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, W'(16'h12 + k));
      drive(1'b1, 1'b1, 16'h15);
      n_cmp++; if (a_cnt !== 4'd4) begin n_fail++; $display("FAIL simul_half_count: got %0d want 4", a_cnt); end
      n_cmp++; if (a_dout !== 16'h11) begin n_fail++; $display("FAIL simul_half_data: got %h want 0011", a_dout); end
      for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, W'(16'h16 + k));
      n_cmp++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL simul_reach_full: got %b want 1", a_full); end
      drive(1'b1, 1'b1, 16'h99);
      n_cmp++; if (a_cnt !== 4'd7) begin n_fail++; $display("FAIL simul_full_count: got %0d want 7", a_cnt); end
      n_cmp++; if (a_ovf !== 1'b0 || a_ack !== 1'b0) begin n_fail++; $display("FAIL simul_full_ovf_ack: got %b%b want 00", a_ovf, a_ack); end
      n_cmp++; if (a_dout !== 16'h12) begin n_fail++; $display("FAIL simul_full_data: got %h want 0012", a_dout); end
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, 1'b1, '0);
         n_cmp++; if (a_dout !== e8_dout || a_dout !== W'(16'h13 + k)) begin n_fail++; $display("FAIL simul_drain[%0d]: got %h want %h", k, a_dout, W'(16'h13 + k)); end
      end
   endtask

   task automatic test_wrap_depth5();
      logic [W-1:0] nd;
      logic [W-1:0] nr;
      apply_reset();
      nd = 16'h100; nr = 16'h100;
      for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b0, nd); nd++; end
      for (int i = 0; i < 20; i++) begin
         logic w, r;
         w = (i % 5 != 4);
         r = (i % 5 != 2);
         drive(w, r, nd);
         if (w) nd++;
         if (r) begin
            n_cmp++; if (b_dout !== nr || b_dout !== e5_dout) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, b_dout, nr); end
            nr++;
         end
         n_cmp++; if (b_cnt !== 3'(q5.size())) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, b_cnt, q5.size()); end
         n_cmp++;
         if ({b_full, b_empty, b_ae, b_ovf, b_unf} !== 5'b0 || b_af !== (q5.size() >= 4)) begin
            n_fail++; $display("FAIL wrap_flags[%0d]: got f%b e%b ae%b af%b o%b u%b want f0 e0 ae0 af%b o0 u0",
                               i, b_full, b_empty, b_ae, b_af, b_ovf, b_unf, (q5.size() >= 4));
         end
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, '0);
         n_cmp++; if (b_dout !== nr) begin n_fail++; $display("FAIL wrap_drain[%0d]: got %h want %h", k, b_dout, nr); end
         nr++;
      end
      n_cmp++; if (b_empty !== 1'b1 || b_cnt !== 3'd0) begin n_fail++; $display("FAIL wrap_empty: got %b/%0d want 1/0", b_empty, b_cnt); end
   endtask

   task automatic test_fwft();
      apply_reset();
      drive(1'b1, 1'b0, 16'h2A);
      n_cmp++; if (f_dout !== 16'h2A || f_empty !== 1'b0) begin n_fail++; $display("FAIL fwft_show: got %h/%b want 002a/0", f_dout, f_empty); end
      drive(1'b0, 1'b0, '0);
      n_cmp++; if (f_dout !== 16'h2A) begin n_fail++; $display("FAIL fwft_hold: got %h want 002a", f_dout); end
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, W'(16'h2B + k));
      n_cmp++; if (f_dout !== 16'h2A || f_cnt !== 4'd4) begin n_fail++; $display("FAIL fwft_head: got %h/%0d want 002a/4", f_dout, f_cnt); end
      drive(1'b0, 1'b1, '0);
      n_cmp++; if (f_dout !== 16'h2B || f_dout !== q8[0]) begin n_fail++; $display("FAIL fwft_pop: got %h want 002b", f_dout); end
      n_cmp++; if (f_cnt !== 4'd3) begin n_fail++; $display("FAIL fwft_count3: got %0d want 3", f_cnt); end
      rst_n = 1'b0;
      #2;
      n_cmp++; if (f_cnt !== 4'd0 || f_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_async_reset: got %0d/%b want 0/1", f_cnt, f_empty); end
      n_cmp++; if (f_dout !== 16'h0) begin n_fail++; $display("FAIL fwft_reset_data: got %h want 0000", f_dout); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      drive(1'b1, 1'b0, 16'h55);
      n_cmp++; if (f_dout !== 16'h55) begin n_fail++; $display("FAIL fwft_after_reset: got %h want 0055", f_dout); end
      n_cmp++; if (u_f.u_mem.mem_q[0] !== 16'h55) begin n_fail++; $display("FAIL fwft_index0: got %h want 0055", u_f.u_mem.mem_q[0]); end
      drive(1'b0, 1'b1, '0);
      n_cmp++; if (f_dout !== 16'h0 || f_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_to_empty: got %h/%b want 0000/1", f_dout, f_empty); end
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      finished_driving = 1'b0;
      test_finished    = 1'b0;
      model_clear();
      test_reset();
      test_fill_full();
      test_drain_underflow();
      test_simultaneous();
      test_wrap_depth5();
      test_fwft();
      finished_driving = 1'b1;
      test_finished    = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
